// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around an external dual-port RAM with
// registered read; a 2-entry head/skid stage hides the read latency.
module dpram_fifo_ctrl #(
  parameter int ADRW = 8,
  parameter int DATW = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DATW-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DATW-1:0] out_data,
  output logic [ADRW+1:0] count,
  output logic            ram_wren_a,
  output logic [ADRW-1:0] ram_address_a,
  output logic [DATW-1:0] ram_data_a,
  output logic            ram_wren_b,
  output logic [ADRW-1:0] ram_address_b,
  input  logic [DATW-1:0] ram_q_b
);

  localparam logic [ADRW:0] RAM_FULL = {1'b1, {ADRW{1'b0}}};

  logic [ADRW:0]   wptr, rptr, ro;
  logic            rd_pend;
  logic [1:0]      oc, oc_next;
  logic [DATW-1:0] head, skid;
  logic            push, pop, issue, head_free;
  logic [2:0]      inflight;

  // One spare pointer bit distinguishes a full RAM from an empty one.
  assign ro       = wptr - rptr;
  assign in_ready = !reset && (ro != RAM_FULL);
  assign push     = in_valid && in_ready;

  assign ram_wren_a    = push;
  assign ram_address_a = wptr[ADRW-1:0];
  assign ram_data_a    = in_data;
  assign ram_wren_b    = 1'b0;
  assign ram_address_b = rptr[ADRW-1:0];

  assign out_valid = (oc != 2'd0);
  assign out_data  = head;
  assign pop       = out_valid && out_ready;

  // Words already owed to the output stage after this cycle's pop; never
  // underflows because a pop needs oc >= 1.
  assign inflight = {1'b0, oc} + {2'b00, rd_pend} - {2'b00, pop};
  assign issue    = (ro != '0) && (inflight < 3'd2);

  assign oc_next   = oc + {1'b0, rd_pend} - {1'b0, pop};
  assign head_free = (oc == 2'd0) || (oc == 2'd1 && pop);

  assign count = {1'b0, ro} + {{(ADRW+1){1'b0}}, rd_pend} + {{ADRW{1'b0}}, oc};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (push)  wptr <= wptr + (ADRW+1)'(1);
      if (issue) rptr <= rptr + (ADRW+1)'(1);
      rd_pend <= issue;
    end
  end

  // NOTE: only the small output stage is reset; the RAM array keeps stale
  // data, which is harmless because the pointers define what is valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oc   <= 2'd0;
      head <= '0;
      skid <= '0;
    end else begin
      oc <= oc_next;
      if (pop && oc == 2'd2) head <= skid;
      if (rd_pend) begin
        if (head_free) head <= ram_q_b;
        else           skid <= ram_q_b;
      end
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl (ADRW=2) with a behavioural RAM and a
// queue model of the stored words.
module tb_dpram_fifo_ctrl;

  localparam int ADRW = 2;
  localparam int DATW = 8;

  logic            clock;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [DATW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [DATW-1:0] out_data;
  logic [ADRW+1:0] count;
  logic            ram_wren_a;
  logic [ADRW-1:0] ram_address_a;
  logic [DATW-1:0] ram_data_a;
  logic            ram_wren_b;
  logic [ADRW-1:0] ram_address_b;
  logic [DATW-1:0] ram_q_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  bit pushed, popped;

  dpram_fifo_ctrl #(.ADRW(ADRW), .DATW(DATW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .ram_wren_a(ram_wren_a), .ram_address_a(ram_address_a), .ram_data_a(ram_data_a),
    .ram_wren_b(ram_wren_b), .ram_address_b(ram_address_b), .ram_q_b(ram_q_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered-read RAM; a same-address read during write returns X so any
  // collision would corrupt the data stream.
  logic [DATW-1:0] mem [2**ADRW];
  always @(posedge clock) begin
    if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
    if (ram_wren_a && ram_address_a == ram_address_b) ram_q_b <= 'x;
    else                                              ram_q_b <= mem[ram_address_b];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: apply inputs, compare against the queue model, advance an edge.
  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    logic [7:0] e;
    in_valid = v; in_data = d; out_ready = r;
    #1;
    check("count", 32'(count), 32'(q.size()));
    check("wren_b", 32'(ram_wren_b), 32'd0);
    check("wren_a", 32'(ram_wren_a), 32'(v && in_ready));
    check("ov_without_data", 32'(out_valid && q.size() == 0), 32'd0);
    if (ram_wren_a) check("data_a", 32'(ram_data_a), 32'(d));
    pushed = v && in_ready;
    popped = out_valid && r;
    if (popped && q.size() != 0) begin
      e = q.pop_front();
      check("out_data", 32'(out_data), 32'(e));
    end
    if (pushed) q.push_back(d);
    @(posedge clock); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, first, last, npop;
    bit fill;
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wren_a", 32'(ram_wren_a), 32'd0);
    check("rst_wren_b", 32'(ram_wren_b), 32'd0);
    check("rst_addr_a", 32'(ram_address_a), 32'd0);
    check("rst_addr_b", 32'(ram_address_b), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Reset mid-stream, then a single word after release.
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    drive(1'b1, 8'h33, 1'b0);
    check("pre_reset_ov", 32'(out_valid), 32'd1);
    in_valid = 1'b1; in_data = 8'h44; reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_wren_a", 32'(ram_wren_a), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    #2;
    reset = 1'b0; in_valid = 1'b0;
    q.delete();
    #1;
    check("mid_rst_in_ready_back", 32'(in_ready), 32'd1);
    drive(1'b1, 8'h5A, 1'b0);
    check("5a_ov_c1", 32'(out_valid), 32'd0);
    drive(1'b0, 8'h00, 1'b0);
    check("5a_ov_c2", 32'(out_valid), 32'd0);
    drive(1'b0, 8'h00, 1'b0);
    check("5a_ov_c3", 32'(out_valid), 32'd1);
    check("5a_data", 32'(out_data), 32'h5A);
    check("5a_count", 32'(count), 32'd1);
    drive(1'b0, 8'h00, 1'b1);

    // Single word with the consumer always ready.
    drive(1'b1, 8'hA5, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    check("a5_no_pop_c1", 32'(popped), 32'd0);
    drive(1'b0, 8'h00, 1'b1);
    check("a5_no_pop_c2", 32'(popped), 32'd0);
    drive(1'b0, 8'h00, 1'b1);
    check("a5_pop_c3", 32'(popped), 32'd1);
    check("a5_count_after", 32'(count), 32'd0);
    check("a5_ov_after", 32'(out_valid), 32'd0);

    // Fill to full under backpressure: 4 in RAM + 2 in the output stage.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(i + 1), 1'b0);
      check("fill_accept", 32'(pushed), 32'(i < 6));
    end
    check("full_count", 32'(count), 32'd6);
    check("full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      check("drain_each_cycle", 32'(popped), 32'd1);
    end
    check("drained_count", 32'(count), 32'd0);

    // Streaming 32 words at full rate.
    sent = 0; first = -1; last = -1; npop = 0;
    for (int i = 0; i < 40; i++) begin
      drive(sent < 32, 8'(sent), 1'b1);
      if (pushed) sent++;
      if (popped) begin
        if (first < 0) first = i;
        last = i;
        npop++;
      end
      check("stream_count_le3", 32'(count <= 3), 32'd1);
    end
    check("stream_first_pop", 32'(first), 32'd3);
    check("stream_last_pop", 32'(last), 32'd34);
    check("stream_pops", 32'(npop), 32'd32);

    // Random valid/ready, 200 words, with wrap-around.
    sent = 0;
    for (int c = 0; c < 4000 && (sent < 200 || q.size() != 0); c++) begin
      drive((sent < 200) && ($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)),
            $urandom_range(0, 1) == 1);
      if (pushed) sent++;
    end
    check("rand_all_sent", 32'(sent), 32'd200);
    check("rand_all_popped", 32'(q.size()), 32'd0);

    // Alternate between full and empty to stress pointer equality.
    fill = 1'b1; sent = 0;
    for (int c = 0; c < 50; c++) begin
      drive(fill, 8'(sent + 8'h80), !fill);
      if (pushed) sent++;
      if (fill && !in_ready) fill = 1'b0;
      else if (!fill && q.size() == 0) fill = 1'b1;
    end
    for (int c = 0; c < 20 && q.size() != 0; c++) drive(1'b0, 8'h00, 1'b1);
    check("collide_drained", 32'(q.size()), 32'd0);
    check("collide_count", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
